wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_queue.sv | 76 +++++++
 rtl/wb_arbiter.sv | 90 +++++++++
 tb/tb_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the register-file write arbiter
package wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam logic [RA_W-1:0] X0 = '0;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [XLEN-1:0] rd_onehot(input logic [RA_W-1:0] rd);
    return XLEN'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - FPU result FIFO with per-entry live bits, kill-by-rd and head-skip
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  wb_req_t         push_req,
  input  logic            pop,
  input  logic            kill_en,
  input  logic [RA_W-1:0] kill_rd,
  output wb_req_t         head,
  output logic            empty,
  output logic            full,
  output logic [XLEN-1:0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [RA_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    rptr, wptr, rptr1, hsel;
  logic [CW-1:0]    count;
  logic             h0_live, h1_live, drop0;
  logic [1:0]       leave_n;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rptr1   = rptr + 1'b1;
  assign h0_live = !empty && live[rptr];
  assign h1_live = (count >= CW'(2)) && live[rptr1];
  // A dead head is dropped silently so the entry behind it can write in the same cycle.
  assign drop0   = !empty && !live[rptr];
  assign hsel    = h0_live ? rptr : rptr1;
  assign leave_n = {1'b0, drop0} + {1'b0, pop};

  assign head.we   = h0_live || (drop0 && h1_live);
  assign head.rd   = rd_mem[hsel];
  assign head.data = data_mem[hsel];

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending = pending | rd_onehot(rd_mem[i]);
  end

  always_ff @(posedge clk) begin
    if (push_req.we) begin
      rd_mem[wptr]   <= push_req.rd;
      data_mem[wptr] <= push_req.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      live  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && rd_mem[i] == kill_rd) live[i] <= 1'b0;
      if (pop) live[hsel] <= 1'b0;
      if (push_req.we) begin
        live[wptr] <= 1'b1;
        wptr       <= wptr + 1'b1;
      end
      rptr  <= rptr + AW'(leave_n);
      count <= count + CW'(push_req.we) - CW'(leave_n);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges pipeline writeback and queued FPU results onto one register-file write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_we,
  input  logic [RA_W-1:0] pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            fpu_valid,
  output logic            fpu_ready,
  input  logic [RA_W-1:0] fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_addr,
  output logic [XLEN-1:0] rf_data,
  output logic [XLEN-1:0] rd_pending,
  output logic            pipe_stall,
  output logic            proto_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  wb_req_t       push_req, head;
  logic          q_empty, q_full;
  logic          pipe_win, fpu_live, pop, bypass;
  logic [SW-1:0] starve, starve_next;

  assign pipe_win  = pipe_we && (pipe_rd != X0);
  assign fpu_ready = !q_full;
  assign fpu_live  = fpu_valid && fpu_ready && (fpu_rd != X0);
  assign pop       = head.we && !pipe_win;
  assign bypass    = fpu_live && !pipe_win && q_empty;

  assign push_req.we   = fpu_live && (pipe_win || !q_empty);
  assign push_req.rd   = fpu_rd;
  assign push_req.data = fpu_data;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (push_req),
    .pop      (pop),
    .kill_en  (pipe_win),
    .kill_rd  (pipe_rd),
    .head     (head),
    .empty    (q_empty),
    .full     (q_full),
    .pending  (rd_pending)
  );

  always_comb begin
    starve_next = starve;
    if (pop || q_empty)
      starve_next = '0;
    else if (head.we && pipe_win && starve < LIM)
      starve_next = starve + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      starve     <= '0;
      pipe_stall <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      rf_we      <= pipe_win || pop || bypass;
      starve     <= starve_next;
      pipe_stall <= (starve_next >= LIM);
      proto_err  <= proto_err || (pipe_we && pipe_stall);
      if (pipe_win) begin
        rf_addr <= pipe_rd;
        rf_data <= pipe_data;
      end else if (pop) begin
        rf_addr <= head.rd;
        rf_data <= head.data;
      end else if (bypass) begin
        rf_addr <= fpu_rd;
        rf_data <= fpu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] rd_pending;
  logic        pipe_stall;
  logic        proto_err;

  int checks = 0;
  int fails  = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .fpu_valid  (fpu_valid),
    .fpu_ready  (fpu_ready),
    .fpu_rd     (fpu_rd),
    .fpu_data   (fpu_data),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rd_pending (rd_pending),
    .pipe_stall (pipe_stall),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    checks++; if (rf_addr !== 5'd0) begin fails++; $display("FAIL reset_rf_addr got %0d want 0", rf_addr); end
    checks++; if (rf_data !== 32'd0) begin fails++; $display("FAIL reset_rf_data got %h want 0", rf_data); end
    checks++; if (rd_pending !== 32'd0) begin fails++; $display("FAIL reset_pending got %h want 0", rd_pending); end
    checks++; if (pipe_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", pipe_stall); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
    checks++; if (fpu_ready !== 1'b1) begin fails++; $display("FAIL reset_fpu_ready got %b want 1", fpu_ready); end
  endtask

  task automatic test_pipe_write();
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_we = 1'b0;
    checks++; if (rf_we !== 1'b1) begin fails++; $display("FAIL pipe_rf_we got %b want 1", rf_we); end
    checks++; if (rf_addr !== 5'd5) begin fails++; $display("FAIL pipe_rf_addr got %0d want 5", rf_addr); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin fails++; $display("FAIL pipe_rf_data got %h want deadbeef", rf_data); end
    checks++; if (fpu_ready !== 1'b1) begin fails++; $display("FAIL pipe_fpu_ready got %b want 1", fpu_ready); end
    checks++; if (rd_pending !== 32'd0) begin fails++; $display("FAIL pipe_pending got %h want 0", rd_pending); end
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL pipe_idle_we got %b want 0", rf_we); end
    checks++; if (rf_data !== 32'hDEADBEEF) begin fails++; $display("FAIL pipe_hold_data got %h want deadbeef", rf_data); end
  endtask

  task automatic test_bypass();
    do_reset();
    fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h3F800000;
    tick();
    fpu_valid = 1'b0;
    checks++; if (rf_we !== 1'b1) begin fails++; $display("FAIL byp_rf_we got %b want 1", rf_we); end
    checks++; if (rf_addr !== 5'd7) begin fails++; $display("FAIL byp_rf_addr got %0d want 7", rf_addr); end
    checks++; if (rf_data !== 32'h3F800000) begin fails++; $display("FAIL byp_rf_data got %h want 3f800000", rf_data); end
    checks++; if (rd_pending !== 32'd0) begin fails++; $display("FAIL byp_pending got %h want 0", rd_pending); end
  endtask

  task automatic test_fill_drain();
    logic [4:0] rds [4];
    rds[0] = 5'd2; rds[1] = 5'd3; rds[2] = 5'd4; rds[3] = 5'd6;
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      fpu_valid = 1'b1; fpu_rd = rds[i]; fpu_data = 32'h100 + 32'(rds[i]);
      tick();
    end
    fpu_valid = 1'b0;
    checks++; if (fpu_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b want 0", fpu_ready); end
    checks++; if (rd_pending !== 32'h5C) begin fails++; $display("FAIL fill_pending got %h want 5c", rd_pending); end
    checks++; if (rf_addr !== 5'd1) begin fails++; $display("FAIL fill_pipe_addr got %0d want 1", rf_addr); end
    pipe_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== rds[i] || rf_data !== 32'h100 + 32'(rds[i])) begin
        fails++;
        $display("FAIL drain_%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, rf_we, rf_addr, rf_data, rds[i], 32'h100 + 32'(rds[i]));
      end
    end
    checks++; if (rd_pending !== 32'd0) begin fails++; $display("FAIL drain_pending got %h want 0", rd_pending); end
    checks++; if (fpu_ready !== 1'b1) begin fails++; $display("FAIL drain_ready got %b want 1", fpu_ready); end
  endtask

  task automatic test_kill();
    int bad = 0;
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h11;
    tick();
    fpu_valid = 1'b0;
    checks++; if (rd_pending !== 32'h200) begin fails++; $display("FAIL kill_pending_set got %h want 200", rd_pending); end
    pipe_rd = 5'd9; pipe_data = 32'h22;
    tick();
    pipe_we = 1'b0;
    checks++; if (rd_pending !== 32'd0) begin fails++; $display("FAIL kill_pending_clr got %h want 0", rd_pending); end
    checks++; if (rf_addr !== 5'd9 || rf_data !== 32'h22) begin fails++; $display("FAIL kill_pipe_wr got addr=%0d data=%h want 9/22", rf_addr, rf_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rf_we === 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL kill_stale_write got %0d writes want 0", bad); end
    checks++; if (rf_data !== 32'h22) begin fails++; $display("FAIL kill_last_data got %h want 22", rf_data); end
  endtask

  task automatic test_starve();
    do_reset();
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    fpu_valid = 1'b1; fpu_rd = 5'd10; fpu_data = 32'hA;
    tick();
    fpu_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        checks++; if (pipe_stall !== 1'b0) begin fails++; $display("FAIL starve_early got %b want 0", pipe_stall); end
      end
    end
    checks++; if (pipe_stall !== 1'b1) begin fails++; $display("FAIL starve_stall got %b want 1", pipe_stall); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL starve_no_err got %b want 0", proto_err); end
    tick();
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_set got %b want 1", proto_err); end
    checks++; if (rf_addr !== 5'd1 || pipe_stall !== 1'b1) begin fails++; $display("FAIL proto_pipe_wins got addr=%0d stall=%b want 1/1", rf_addr, pipe_stall); end
    pipe_we = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_data !== 32'hA) begin fails++; $display("FAIL starve_drain got we=%b addr=%0d data=%h want 1/10/a", rf_we, rf_addr, rf_data); end
    checks++; if (pipe_stall !== 1'b0) begin fails++; $display("FAIL starve_release got %b want 0", pipe_stall); end
    tick();
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_sticky got %b want 1", proto_err); end
  endtask

  task automatic test_x0_and_async_reset();
    do_reset();
    fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'h55;
    checks++; if (fpu_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got %b want 1", fpu_ready); end
    tick();
    fpu_valid = 1'b0;
    checks++; if (rf_we !== 1'b0 || rd_pending !== 32'd0) begin fails++; $display("FAIL x0_fpu got we=%b pend=%h want 0/0", rf_we, rd_pending); end
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h66;
    tick();
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_pipe got we=%b want 0", rf_we); end
    pipe_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      fpu_valid = 1'b1; fpu_rd = 5'(11 + i); fpu_data = 32'(i);
      tick();
    end
    fpu_valid = 1'b0;
    checks++; if (rd_pending !== 32'h3800) begin fails++; $display("FAIL rst_pre_pending got %h want 3800", rd_pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_pending !== 32'd0 || rf_we !== 1'b0) begin fails++; $display("FAIL async_rst got pend=%h we=%b want 0/0", rd_pending, rf_we); end
    pipe_we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (fpu_ready !== 1'b1 || rf_we !== 1'b0) begin fails++; $display("FAIL post_rst got ready=%b we=%b want 1/0", fpu_ready, rf_we); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_bypass();
    test_fill_drain();
    test_kill();
    test_starve();
    test_x0_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
